// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  localparam int W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // The iteration counter only has to reach W-1, so clog2(W) bits suffice (min 1).
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_sub_unit.sv
// Parameterized N-bit ripple subtractor (d = a - b - bin) built from full-subtractor cells.
module sub_unit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);

  logic [N:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign d[i]       = a[i] ^ b[i] ^ brw[i];
    assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[N];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock over a shared subtractor.
// Define DIV_ZERO_CHK_EN to short-circuit b=0 straight to DONE and raise the dz flag.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  if (W < 2 || W > W_MAX) begin : g_bad_width
    $error("div_seq_ctrl: W must lie in 2..%0d", W_MAX);
  end

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  div_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;

  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          bout;
  logic          take;
  logic [W-1:0]  rem_d;
  logic [W-1:0]  quo_d;

  assign shifted = {rem_q, quo_q[W-1]};

  sub_unit #(.N(W + 1)) u_sub (
    .a   (shifted),
    .b   ({1'b0, div_q}),
    .bin (1'b0),
    .d   (diff),
    .bout(bout)
  );

  // With no borrow diff[W] is always 0 (rem < b bounds it), so folding it in is free.
  always_comb begin
    take  = ~bout & ~diff[W];
    rem_d = take ? diff[W-1:0] : shifted[W-1:0];
    quo_d = {quo_q[W-2:0], take};
  end

`ifdef DIV_ZERO_CHK_EN
  logic dz_q;
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
`ifdef DIV_ZERO_CHK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            div_q <= b;
            rem_q <= '0;
            quo_q <= a;
            cnt_q <= CNT_INIT;
`ifdef DIV_ZERO_CHK_EN
            if (b == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
              q       <= '1;
              r       <= a;
              dz_q    <= 1'b1;
            end else begin
              state_q <= RUN;
              busy    <= 1'b1;
              dz_q    <= 1'b0;
            end
`else
            state_q <= RUN;
            busy    <= 1'b1;
`endif
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            q       <= quo_d;
            r       <= rem_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: a W=4 instance for timing/handshake cases, a W=8 instance for a random sweep.
module tb_div_seq_ctrl;

`ifdef DIV_ZERO_CHK_EN
  localparam bit DZ_ON = 1'b1;
`else
  localparam bit DZ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, busy4, done4, dz4;
  logic [3:0] a4, b4, q4, r4;
  logic       start8, busy8, done8, dz8;
  logic [7:0] a8, b8, q8, r8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .q(q4), .r(r4), .dz(dz4)
  );

  div_seq_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .q(q8), .r(r8), .dz(dz8)
  );

  // Reference result from plain integer division; b=0 gives all ones and r=a.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.dz = (b == 8'd0) && DZ_ON;
    if (b == 8'd0) begin
      e.q = (w == 4) ? 8'h0F : 8'hFF;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b);
    start4 = 1'b1;
    a4     = a;
    b4     = b;
    sb4.push_back(model(4, {4'd0, a}, {4'd0, b}));
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    sb8.push_back(model(8, a, b));
  endtask

  task automatic wait_done4(input bit drop, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (drop && cyc == 1) start4 = 1'b0;
      if (done4 === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_done8(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start8 = 1'b0;
      if (done8 === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy4, done4, q4, r4, dz4} !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL reset4 busy/done/q/r/dz=%b/%b/%0d/%0d/%b want all 0", busy4, done4, q4, r4, dz4);
    end
    compared++;
    if ({busy8, done8, q8, r8, dz8} !== 19'd0) begin
      mismatched++;
      $display("[TB] FAIL reset8 busy/done/q/r/dz=%b/%b/%0d/%0d/%b want all 0", busy8, done8, q8, r8, dz8);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    exp_t e;
    applyStimulus4(4'd13, 4'd4);
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      compared++;
      if (busy4 !== 1'b1 || done4 !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL run_cycle%0d busy/done=%b/%b want 1/0", i, busy4, done4);
      end
      if (i < 4) @(negedge clk);
    end
    @(negedge clk);
    compared++;
    if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL done_cycle busy/done=%b/%b want 0/1", busy4, done4);
    end
    compared++;
    if (sb4.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL latency_sb got result with empty scoreboard");
    end else begin
      e = sb4.pop_front();
      compared++;
      if ({q4, r4, dz4} !== {e.q[3:0], e.r[3:0], e.dz}) begin
        mismatched++;
        $display("[TB] FAIL latency_result q/r/dz=%0d/%0d/%b want %0d/%0d/%b", q4, r4, dz4, e.q, e.r, e.dz);
      end
      @(negedge clk);
      compared++;
      if (done4 !== 1'b0 || q4 !== e.q[3:0] || r4 !== e.r[3:0]) begin
        mismatched++;
        $display("[TB] FAIL done_pulse done/q/r=%b/%0d/%0d want 0/%0d/%0d", done4, q4, r4, e.q, e.r);
      end
    end
  endtask

  task automatic test_values();
    logic [3:0] av[4] = '{4'd15, 4'd3, 4'd0, 4'd15};
    logic [3:0] bv[4] = '{4'd1, 4'd7, 4'd5, 4'd15};
    exp_t e;
    int   cyc;
    bit   seen;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      applyStimulus4(av[k], bv[k]);
      wait_done4(1'b1, cyc, seen);
      compared++;
      if (!seen || cyc != 5 || sb4.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL values%0d seen/latency=%b/%0d want 1/5", k, seen, cyc);
      end else begin
        e = sb4.pop_front();
        compared++;
        if ({q4, r4, dz4} !== {e.q[3:0], e.r[3:0], e.dz}) begin
          mismatched++;
          $display("[TB] FAIL values%0d q/r/dz=%0d/%0d/%b want %0d/%0d/%b", k, q4, r4, dz4, e.q, e.r, e.dz);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    applyStimulus4(4'd13, 4'd4);
    @(negedge clk);
    a4 = 4'd9;
    b4 = 4'd2;
    compared++;
    if (busy4 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_busy busy=%b want 1", busy4);
    end
    wait_done4(1'b0, cyc, seen);
    compared++;
    if (!seen || cyc != 4 || sb4.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_first seen/latency=%b/%0d want 1/4", seen, cyc);
    end else begin
      e = sb4.pop_front();
      compared++;
      if ({q4, r4} !== {e.q[3:0], e.r[3:0]}) begin
        mismatched++;
        $display("[TB] FAIL b2b_first_result q/r=%0d/%0d want %0d/%0d", q4, r4, e.q, e.r);
      end
    end
    sb4.push_back(model(4, 8'd9, 8'd2));
    @(negedge clk);
    compared++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_idle busy/done=%b/%b want 0/0", busy4, done4);
    end
    @(negedge clk);
    start4 = 1'b0;
    compared++;
    if (busy4 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_restart busy=%b want 1", busy4);
    end
    wait_done4(1'b0, cyc, seen);
    compared++;
    if (!seen || cyc != 4 || sb4.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_second seen/latency=%b/%0d want 1/4", seen, cyc);
    end else begin
      e = sb4.pop_front();
      compared++;
      if ({q4, r4} !== {e.q[3:0], e.r[3:0]}) begin
        mismatched++;
        $display("[TB] FAIL b2b_second_result q/r=%0d/%0d want %0d/%0d", q4, r4, e.q, e.r);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    start4 = 1'b1;
    a4     = 4'd13;
    b4     = 4'd4;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({busy4, done4, q4, r4} !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset busy/done/q/r=%b/%b/%0d/%0d want 0/0/0/0", busy4, done4, q4, r4);
    end
    rst_n = 1'b1;
    applyStimulus4(4'd9, 4'd2);
    wait_done4(1'b1, cyc, seen);
    compared++;
    if (!seen || cyc != 5 || sb4.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL after_reset seen/latency=%b/%0d want 1/5", seen, cyc);
    end else begin
      e = sb4.pop_front();
      compared++;
      if ({q4, r4} !== {e.q[3:0], e.r[3:0]}) begin
        mismatched++;
        $display("[TB] FAIL after_reset_result q/r=%0d/%0d want %0d/%0d", q4, r4, e.q, e.r);
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    int   cyc;
    bit   seen;
    int   wantCyc;
    wantCyc = DZ_ON ? 1 : 5;
    @(negedge clk);
    applyStimulus4(4'd6, 4'd0);
    wait_done4(1'b1, cyc, seen);
    compared++;
    if (!seen || cyc != wantCyc || sb4.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL divzero seen/latency=%b/%0d want 1/%0d", seen, cyc, wantCyc);
    end else begin
      e = sb4.pop_front();
      compared++;
      if ({q4, r4, dz4} !== {e.q[3:0], e.r[3:0], e.dz}) begin
        mismatched++;
        $display("[TB] FAIL divzero_result q/r/dz=%0d/%0d/%b want %0d/%0d/%b", q4, r4, dz4, e.q, e.r, e.dz);
      end
    end
    @(negedge clk);
    compared++;
    if (dz4 !== DZ_ON) begin
      mismatched++;
      $display("[TB] FAIL dz_hold dz=%b want %b", dz4, DZ_ON);
    end
    applyStimulus4(4'd13, 4'd4);
    wait_done4(1'b1, cyc, seen);
    compared++;
    if (!seen || sb4.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL dz_clear_op seen=%b want 1", seen);
    end else begin
      e = sb4.pop_front();
      compared++;
      if ({q4, r4, dz4} !== {e.q[3:0], e.r[3:0], e.dz}) begin
        mismatched++;
        $display("[TB] FAIL dz_clear q/r/dz=%0d/%0d/%b want %0d/%0d/%b", q4, r4, dz4, e.q, e.r, e.dz);
      end
    end
  endtask

  task automatic test_sweep8();
    exp_t       e;
    int         cyc;
    bit         seen;
    logic [7:0] ra, rb;
    for (int k = 0; k < 504; k++) begin
      case (k)
        0:       begin ra = 8'd255; rb = 8'd1;   end
        1:       begin ra = 8'd255; rb = 8'd255; end
        2:       begin ra = 8'd0;   rb = 8'd7;   end
        3:       begin ra = 8'd128; rb = 8'd3;   end
        default: begin ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(1, 255)); end
      endcase
      @(negedge clk);
      applyStimulus8(ra, rb);
      wait_done8(cyc, seen);
      compared++;
      if (!seen || cyc != 9 || sb8.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL sweep%0d seen/latency=%b/%0d want 1/9", k, seen, cyc);
      end else begin
        e = sb8.pop_front();
        compared++;
        if ({q8, r8} !== {e.q, e.r}) begin
          mismatched++;
          $display("[TB] FAIL sweep%0d %0d/%0d q/r=%0d/%0d want %0d/%0d", k, e.a, e.b, q8, r8, e.q, e.r);
        end
        compared++;
        if ((int'(q8) * int'(e.b) + int'(r8)) != int'(e.a) || r8 >= e.b) begin
          mismatched++;
          $display("[TB] FAIL sweep%0d_identity q*b+r=%0d want %0d, r=%0d b=%0d", k,
                   int'(q8) * int'(e.b) + int'(r8), e.a, r8, e.b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_div_zero();
    test_sweep8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
